cordic_sequencer: RTL
=====================

# cordic_sequencer

Hardware controller that sequences one iterative CORDIC core, replacing the software-style load/iterate loop with a command/result handshake. Each command carries initial x, y, z plus system/mode and an iteration count. The block loads the core, issues the requested number of single-step iterations, aborts early on core overflow, and holds the captured result until the consumer accepts it. It sits between a host-side command source and the `cordic` core's controller-facing signals.

## Interface
- p_WIDTH, 32, datapath width of x, y, z (raw two's-complement bits; number format is opaque to this block)
- p_ITER_W, 5, width of iteration-count fields (max 2^p_ITER_W−1 iterations)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x, cmd_y, cmd_z  in  p_WIDTH each  initial x, y, angle
- cmd_system  in  1  1 circular, 0 hyperbolic
- cmd_mode  in  1  1 rotation, 0 vectoring
- cmd_iter  in  p_ITER_W  iterations requested (N)
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_x, res_y, res_z  out  p_WIDTH each  captured core outputs
- res_overflow  out  1  core overflowed; result is partial
- res_iters  out  p_ITER_W  iterations actually completed
- busy  out  1  state ≠ IDLE
- core_load  out  1  one-cycle pulse: core loads core_x/y/z, clears its overflow flag
- core_en  out  1  one-cycle pulse per single CORDIC iteration
- core_x, core_y, core_z  out  p_WIDTH each  initial values to core
- core_system, core_mode  out  1 each  configuration to core, held stable from LOAD until IDLE
- core_x_in, core_y_in, core_z_in  in  p_WIDTH each  core state (registered in core, reflects all loads/iterations up to previous edge)
- core_overflow  in  1  registered core flag, set the cycle after the overflowing iteration

## Operation
- FSM states: IDLE, LOAD, ITER, DONE. Reset → IDLE.
- IDLE: cmd_ready=1. On cmd_valid: latch cmd_x/y/z/system/mode/iter into command regs (drive core_* outputs), cnt←0, → LOAD.
- LOAD: core_load=1 for exactly this cycle, → ITER.
- ITER, evaluated each cycle in priority order:
  - core_overflow=1: capture core_*_in into res_x/y/z, res_overflow←1, res_iters←cnt, no core_en, → DONE.
  - cnt==N: capture core_*_in, res_overflow←0, res_iters←N, no core_en, → DONE.
  - else: core_en=1, cnt←cnt+1, stay.
- DONE: res_valid=1; outputs stable. On res_ready → IDLE.
- cmd_ready is 0 outside IDLE; commands are never queued. cnt is p_ITER_W bits; cannot wrap because it stops at N.
- N=0: no core_en; result = loaded values, res_iters=0.
- core_load and core_en are never high in the same cycle.

## Timing
- Reset values: cmd_ready=1 (IDLE), res_valid=0, busy=0, core_load=0, core_en=0, core_x/y/z=0, core_system=0, core_mode=0, res_x/y/z=0, res_overflow=0, res_iters=0.
- Command accepted at edge T (cmd_valid & cmd_ready): LOAD in cycle T+1, ITER cycles T+2..T+N+2, core_en high in T+2..T+N+1, res_valid first high in T+N+3.
- Overflow after iteration k (core_en in T+1+k): core_overflow seen in T+2+k, no further core_en, res_valid in T+3+k with res_iters=k.
- Result accepted at edge with res_valid & res_ready → IDLE next cycle; earliest next command accepted one cycle after result handshake (no same-cycle reuse).
- rst asserted in any state: immediate return to IDLE, all outputs to reset values, in-flight command and result discarded; core_en/core_load drop asynchronously.

## Test plan
- Normal: x=0x4DBA76D4, y=0, z=0x20000000, system=1, mode=1, N=10, res_ready=1 -> exactly one core_load at T+1, 10 core_en pulses T+2..T+11, res_valid at T+13, res_* equals bench core model after 10 steps, res_overflow=0, res_iters=10.
- Overflow: model raises core_overflow after 4th iteration, N=10 -> 4 core_en pulses, res_overflow=1, res_iters=4, res_valid at T+7.
- Zero iterations: N=0, x=0x12345678 -> no core_en, res_x=0x12345678, res_iters=0, res_valid at T+3.
- Backpressure: res_ready low 5 cycles after res_valid -> res_* stable, cmd_ready=0, second cmd_valid ignored; accepted one cycle after res handshake.
- Reset mid-ITER: rst at cycle T+5 of N=10 -> same cycle core_en=0, busy=0, cmd_ready=1, res_* zero; next command runs full sequence with fresh cnt.
- Max count: N=31 -> 31 core_en pulses, res_iters=31, no wrap.

Source files
------------

// File: rtl/cordic_sequencer_if.sv
// Command, result and core-control signals for cordic_sequencer.
// The slave modport is the sequencer's view; master is the host-plus-core side.
interface cordic_sequencer_if #(
  parameter int p_WIDTH  = 32,
  parameter int p_ITER_W = 5
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic signed [p_WIDTH-1:0]  cmd_x;
  logic signed [p_WIDTH-1:0]  cmd_y;
  logic signed [p_WIDTH-1:0]  cmd_z;
  logic                       cmd_system;
  logic                       cmd_mode;
  logic [p_ITER_W-1:0]        cmd_iter;

  logic                       res_valid;
  logic                       res_ready;
  logic signed [p_WIDTH-1:0]  res_x;
  logic signed [p_WIDTH-1:0]  res_y;
  logic signed [p_WIDTH-1:0]  res_z;
  logic                       res_overflow;
  logic [p_ITER_W-1:0]        res_iters;

  logic                       busy;

  logic                       core_load;
  logic                       core_en;
  logic signed [p_WIDTH-1:0]  core_x;
  logic signed [p_WIDTH-1:0]  core_y;
  logic signed [p_WIDTH-1:0]  core_z;
  logic                       core_system;
  logic                       core_mode;
  logic signed [p_WIDTH-1:0]  core_x_in;
  logic signed [p_WIDTH-1:0]  core_y_in;
  logic signed [p_WIDTH-1:0]  core_z_in;
  logic                       core_overflow;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_z, cmd_system, cmd_mode, cmd_iter,
    output cmd_ready,
    output res_valid, res_x, res_y, res_z, res_overflow, res_iters,
    input  res_ready,
    output busy,
    output core_load, core_en, core_x, core_y, core_z, core_system, core_mode,
    input  core_x_in, core_y_in, core_z_in, core_overflow
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_z, cmd_system, cmd_mode, cmd_iter,
    input  cmd_ready,
    input  res_valid, res_x, res_y, res_z, res_overflow, res_iters,
    output res_ready,
    input  busy,
    input  core_load, core_en, core_x, core_y, core_z, core_system, core_mode,
    output core_x_in, core_y_in, core_z_in, core_overflow
  );
endinterface

// File: rtl/cordic_sequencer.sv
// Drives one iterative CORDIC core through load, N single-step iterations and
// result capture, exposing it as a command/result handshake.
module cordic_sequencer #(
  parameter int p_WIDTH  = 32,
  parameter int p_ITER_W = 5
) (
  input logic               clk,
  input logic               rst,
  cordic_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_accept;
  logic w_load;
  logic w_en;
  logic w_cap;

  logic signed [p_WIDTH-1:0] r_cmd_x;
  logic signed [p_WIDTH-1:0] r_cmd_y;
  logic signed [p_WIDTH-1:0] r_cmd_z;
  logic                      r_cmd_system;
  logic                      r_cmd_mode;
  logic [p_ITER_W-1:0]       r_cmd_iter;
  logic [p_ITER_W-1:0]       r_cnt;

  logic signed [p_WIDTH-1:0] r_res_x;
  logic signed [p_WIDTH-1:0] r_res_y;
  logic signed [p_WIDTH-1:0] r_res_z;
  logic                      r_res_overflow;
  logic [p_ITER_W-1:0]       r_res_iters;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Overflow outranks the count check so a partial result is never reported as complete.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_en     = 1'b0;
    w_cap    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_accept = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_ITER;
      end
      S_ITER: begin
        if (bus.core_overflow || (r_cnt == r_cmd_iter)) begin
          w_cap  = 1'b1;
          w_next = S_DONE;
        end else begin
          w_en = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_x      <= '0;
      r_cmd_y      <= '0;
      r_cmd_z      <= '0;
      r_cmd_system <= 1'b0;
      r_cmd_mode   <= 1'b0;
      r_cmd_iter   <= '0;
    end else if (w_accept) begin
      r_cmd_x      <= bus.cmd_x;
      r_cmd_y      <= bus.cmd_y;
      r_cmd_z      <= bus.cmd_z;
      r_cmd_system <= bus.cmd_system;
      r_cmd_mode   <= bus.cmd_mode;
      r_cmd_iter   <= bus.cmd_iter;
    end
  end

  // Counter stops at N, so it never needs to wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_cnt <= '0;
    else if (w_accept) r_cnt <= '0;
    else if (w_en)     r_cnt <= r_cnt + p_ITER_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_x        <= '0;
      r_res_y        <= '0;
      r_res_z        <= '0;
      r_res_overflow <= 1'b0;
      r_res_iters    <= '0;
    end else if (w_cap) begin
      r_res_x        <= bus.core_x_in;
      r_res_y        <= bus.core_y_in;
      r_res_z        <= bus.core_z_in;
      r_res_overflow <= bus.core_overflow;
      r_res_iters    <= r_cnt;
    end
  end

  // Strobes decode straight from the async-reset state so they drop with rst.
  assign bus.cmd_ready    = (r_state == S_IDLE);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.res_valid    = (r_state == S_DONE);
  assign bus.core_load    = w_load;
  assign bus.core_en      = w_en;
  assign bus.core_x       = r_cmd_x;
  assign bus.core_y       = r_cmd_y;
  assign bus.core_z       = r_cmd_z;
  assign bus.core_system  = r_cmd_system;
  assign bus.core_mode    = r_cmd_mode;
  assign bus.res_x        = r_res_x;
  assign bus.res_y        = r_res_y;
  assign bus.res_z        = r_res_z;
  assign bus.res_overflow = r_res_overflow;
  assign bus.res_iters    = r_res_iters;

endmodule
